// File: rtl/stack_unit_if.sv
// Operand stack port bundle between the control FSM/datapath and stack_unit.
// Error ports exist only when STACK_ERR_EN is defined.
interface stack_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic             tos;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
`ifdef STACK_ERR_EN
  logic             clr_err;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, tos, din, clr_err,
    input  dout, count, empty, full,
    input  overflow, underflow
  );
  modport slave (
    input  push, pop, tos, din, clr_err,
    output dout, count, empty, full,
    output overflow, underflow
  );
`else
  modport master (
    output push, pop, tos, din,
    input  dout, count, empty, full
  );
  modport slave (
    input  push, pop, tos, din,
    output dout, count, empty, full
  );
`endif
endinterface

// File: rtl/stack_unit.sv
// Register-file operand stack executing push/pop/tos strobes.
// Define STACK_ERR_EN for sticky overflow/underflow flags with clr_err.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic        clk,
  input logic        rst,
  stack_unit_if.slave s
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             we;
  logic [AW-1:0]    wa;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CW'(DEPTH));
  // Low bits of sp minus one stay correct even at sp == DEPTH.
  assign top_idx  = sp_q[AW-1:0] - AW'(1);
  assign top      = mem[top_idx];

  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    we     = 1'b0;
    wa     = '0;
    if (s.pop && !is_empty) begin
      dout_d = top;
      if (s.push) begin
        we = 1'b1;
        wa = top_idx;
      end else begin
        sp_d = sp_q - CW'(1);
      end
    end else begin
      if (s.tos && !is_empty)
        dout_d = top;
      if (s.push && !is_full) begin
        we   = 1'b1;
        wa   = sp_q[AW-1:0];
        sp_d = sp_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[wa] <= s.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
    end
  end

  assign s.dout  = dout_q;
  assign s.count = sp_q;
  assign s.empty = is_empty;
  assign s.full  = is_full;

`ifdef STACK_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A new error in the clearing cycle wins over clr_err.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (s.clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (s.push && !s.pop && is_full)
      ovf_d = 1'b1;
    if ((s.pop || s.tos) && is_empty)
      unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign s.overflow  = ovf_q;
  assign s.underflow = unf_q;
`endif
endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: stimulus queues expectations,
// a monitor checks them after each clock edge.
module tb_stack_unit;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    string            nm;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    c;
    logic             ov;
    logic             uf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic exp_ov = 1'b0;
  logic exp_uf = 1'b0;

  always #5 clk = ~clk;

  stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .s  (bus.slave)
  );

  task automatic cmp(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic check_all(input exp_t e);
    logic ee;
    logic ef;
    ee = (e.c == 0);
    ef = (e.c == CW'(DEPTH));
    cmp({e.nm, ".dout"}, int'(bus.dout), int'(e.d));
    cmp({e.nm, ".count"}, int'(bus.count), int'(e.c));
    cmp({e.nm, ".empty"}, int'(bus.empty), int'(ee));
    cmp({e.nm, ".full"}, int'(bus.full), int'(ef));
`ifdef STACK_ERR_EN
    cmp({e.nm, ".ovf"}, int'(bus.overflow), int'(e.ov));
    cmp({e.nm, ".unf"}, int'(bus.underflow), int'(e.uf));
`endif
  endtask

  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_all(e);
    end
  end

  task automatic step(input string nm, input logic p, input logic o,
                      input logic t, input logic [WIDTH-1:0] di,
                      input logic [WIDTH-1:0] ed, input int ec);
    exp_t e;
    @(negedge clk);
    bus.push = p;
    bus.pop  = o;
    bus.tos  = t;
    bus.din  = di;
    e.nm = nm;
    e.d  = ed;
    e.c  = CW'(ec);
    e.ov = exp_ov;
    e.uf = exp_uf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.tos  = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   n;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.tos  = 1'b0;
    bus.din  = '0;
`ifdef STACK_ERR_EN
    bus.clr_err = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    e.nm = "reset"; e.d = 8'h00; e.c = '0; e.ov = 0; e.uf = 0;
    check_all(e);

    step("push11", 1, 0, 0, 8'h11, 8'h00, 1);
    step("push22", 1, 0, 0, 8'h22, 8'h00, 2);
    step("push33", 1, 0, 0, 8'h33, 8'h00, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    e.nm = "async_rst"; e.d = 8'h00; e.c = '0;
    check_all(e);
    @(negedge clk);
    rst = 1'b0;

    step("push11b", 1, 0, 0, 8'h11, 8'h00, 1);
    step("push22b", 1, 0, 0, 8'h22, 8'h00, 2);
    step("push33b", 1, 0, 0, 8'h33, 8'h00, 3);
    step("pop33", 0, 1, 0, 8'h00, 8'h33, 2);
    step("pop22", 0, 1, 0, 8'h00, 8'h22, 1);
    step("pop11", 0, 1, 0, 8'h00, 8'h11, 0);

    step("push5a", 1, 0, 0, 8'h5A, 8'h11, 1);
    step("tos1", 0, 0, 1, 8'h00, 8'h5A, 1);
    step("tos2", 0, 0, 1, 8'h00, 8'h5A, 1);
    step("pop5a", 0, 1, 0, 8'h00, 8'h5A, 0);

    for (int i = 0; i < DEPTH; i++)
      step($sformatf("fill%0d", i), 1, 0, 0, 8'(i), 8'h5A, i + 1);
    exp_ov = 1'b1;
    step("push_full", 1, 0, 0, 8'hFF, 8'h5A, DEPTH);
    for (int i = DEPTH - 1; i >= 0; i--)
      step($sformatf("drain%0d", i), 0, 1, 0, 8'h00, 8'(i), i);

    exp_uf = 1'b1;
    step("pop_empty", 0, 1, 0, 8'h00, 8'h00, 0);
    step("tos_empty", 0, 0, 1, 8'h00, 8'h00, 0);
`ifdef STACK_ERR_EN
    @(negedge clk);
    bus.clr_err = 1'b1;
    exp_ov = 1'b0;
    exp_uf = 1'b0;
    step("clr_err", 0, 0, 0, 8'h00, 8'h00, 0);
    bus.clr_err = 1'b0;
    step("after_clr", 0, 0, 0, 8'h00, 8'h00, 0);
`endif

    step("push01", 1, 0, 0, 8'h01, 8'h00, 1);
    step("push02", 1, 0, 0, 8'h02, 8'h00, 2);
    step("replace", 1, 1, 0, 8'h77, 8'h02, 2);
    step("pop77", 0, 1, 0, 8'h00, 8'h77, 1);
    step("pop01", 0, 1, 0, 8'h00, 8'h01, 0);

    step("push10", 1, 0, 0, 8'h10, 8'h01, 1);
    step("push_tos", 1, 0, 1, 8'h20, 8'h10, 2);
    step("pop20", 0, 1, 0, 8'h00, 8'h20, 1);
    step("idle", 0, 0, 0, 8'h00, 8'h20, 1);
    step("pop10", 0, 1, 0, 8'h00, 8'h10, 0);

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stack_unit.md
# stack_unit

Operand stack for the multicycle stack-machine CPU. It sits directly downstream of the control FSM and executes that FSM's `push`, `pop` and `tos` strobes against a register-file stack. It supplies popped or peeked operands to the datapath's A/B latches through a registered output. Pushed data comes from the datapath, either a memory read or an ALU result, selected upstream.

## Interface
Parameters:
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 16: number of stack entries; power of two, at least 2.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `push`  input  1  write `din` onto the stack this cycle.
- `pop`  input  1  remove the top entry and copy it to `dout`.
- `tos`  input  1  copy the top entry to `dout` without removing it.
- `din`  input  WIDTH  data to push.
- `dout`  output  WIDTH  registered operand output.
- `count`  output  $clog2(DEPTH)+1  number of valid entries.
- `empty`  output  1  `count == 0`.
- `full`  output  1  `count == DEPTH`.
- `clr_err`  input  1  clears the sticky error flags. Present only with `STACK_ERR_EN`.
- `overflow`  output  1  sticky flag: a push was attempted while full. Present only with `STACK_ERR_EN`.
- `underflow`  output  1  sticky flag: a pop or tos was attempted while empty. Present only with `STACK_ERR_EN`.

## Operation
- Storage is a `DEPTH` x `WIDTH` register array indexed by the stack pointer `sp`, which equals `count`.
- The array is not reset. `sp`, `dout` and the error flags are reset.
- The top entry is `mem[sp-1]`.
- Operations are evaluated each cycle, using `sp` as it stood before the edge:
  - **push only:**
    - Not full: `mem[sp] <= din`, `sp <= sp+1`.
    - Full: no change (see error flags).
  - **pop only:**
    - Not empty: `dout <= mem[sp-1]`, `sp <= sp-1`.
    - Empty: `dout` and `sp` are unchanged.
  - **tos only:**
    - Not empty: `dout <= mem[sp-1]`; `sp` is unchanged.
    - Empty: `dout` is unchanged.
  - **push and pop together:** replace-top.
    - Not empty: `dout <= mem[sp-1]`, `mem[sp-1] <= din`, `sp` unchanged.
    - Empty: behaves as push only.
  - **tos together with pop:** `tos` is redundant and ignored.
  - **tos together with push, without pop:** `dout <= mem[sp-1]` (old top) while the push proceeds.
  - **No strobe:** all state holds. `dout` holds its last value indefinitely; the datapath latches it in the following cycle.
- `empty` and `full` are combinational decodes of `sp`. They carry no extra latency.

## Timing
- Reset values: `sp=0`, `count=0`, `empty=1`, `full=0`, `dout=0`, `overflow=0`, `underflow=0`.
- `rst` takes effect immediately and asynchronously. An operation in flight at reset is discarded.
- Data written by a push at edge N is poppable at edge N+1. The value appears on `dout` after edge N+1 (one-cycle latency).
- Pop or tos at edge N: `dout` is valid from edge N until the next pop/tos/reset.
- `count`, `empty` and `full` reflect an operation immediately after its edge.
- Back-to-back push, push, pop, pop sequences on consecutive cycles are supported with no bubbles.
- Boundaries:
  - A push at `count == DEPTH-1` sets `full` after the edge.
  - A pop at `count == 1` sets `empty` after the edge.
  - `sp` never wraps.
- No handshake is used; the control FSM guarantees at most one request per state. The unit still accepts any strobe combination per the rules above.

## Configuration
- `STACK_ERR_EN` defined:
  - `overflow` sets on a push-only attempt while full.
  - `underflow` sets on a pop or tos attempt while empty.
  - Both flags are sticky. They clear only on `clr_err` (synchronous) or `rst`.
  - If `clr_err` and a new error occur in the same cycle, the flag stays set.
- `STACK_ERR_EN` undefined:
  - `clr_err`, `overflow` and `underflow` ports are omitted.
  - The guarding behaviour is unchanged: no write when full, no `sp` change when empty.

## Test plan
- Reset, then idle: `dout=0`, `count=0`, `empty=1`, `full=0`. Assert `rst` mid-sequence with `count=3`: `count` returns to 0 immediately, without a clock edge.
- Push 0x11, 0x22, 0x33, then pop three times: `dout` = 0x33, 0x22, 0x11 on successive cycles. `empty=1` after the third pop.
- Push 0x5A, tos twice: `dout=0x5A` both times, `count=1`. Then pop: `dout=0x5A`, `count=0`.
- Fill to `DEPTH` with values 0..15, then push 0xFF:
  - `full=1`, `count=16`, and `overflow=1` (with macro).
  - Popping 16 times yields 15..0; 0xFF is never returned.
- From empty, pop: `dout` unchanged, `count=0`, and `underflow=1` (with macro). Assert `clr_err` for one cycle: flag returns to 0.
- With stack [0x01, 0x02], drive push=1 and pop=1 with `din=0x77` in the same cycle: `dout=0x02`, `count=2`. A following pop gives `dout=0x77`.
